periph_int_ctrl: RTL

- Peripheral interrupt controller directly upstream of the machine-mode CSR/interrupt unit.
- Collects edge-triggered IRQ lines from on-chip peripherals and latches them as pending.
- Arbitrates by fixed priority and drives a nonzero peripheral_int_code that sets mip[11] in the CSR unit.
- Software claims and completes each interrupt through a small memory-mapped register window.

---
 rtl/periph_int_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/periph_int_ctrl.sv
// periph_int_ctrl: latches rising edges of peripheral IRQ lines as pending and presents the
//   lowest-index enabled source to the CSR unit as peripheral_int_code (index+1, 0 = none).
// Latency: edge sampled at clock k -> pending after k, code after k+1 (k+3 with IRQ_SYNC_EN).
// Flow: one source in flight; software claims via CLAIM read and releases via COMPLETE write.
// Optional build macro IRQ_SYNC_EN: two-flop synchronizer on irq_in for asynchronous sources.

`ifndef INT_CODE_WIDTH
`define INT_CODE_WIDTH 5
`endif

module periph_int_ctrl #(
  parameter int IRQ_NUM = 8,
  parameter int CODE_W  = `INT_CODE_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IRQ_NUM-1:0] irq_in,
  input  logic [3:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  input  logic               reg_we,
  input  logic               reg_re,
  output logic [31:0]        reg_rdata,
  output logic [CODE_W-1:0]  peripheral_int_code,
  output logic               irq_busy
);

  localparam int ID_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

  typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;

  state_t              state_q, state_d;
  logic [IRQ_NUM-1:0]  irq_s;
  logic [IRQ_NUM-1:0]  irq_q;
  logic [IRQ_NUM-1:0]  rise;
  logic [IRQ_NUM-1:0]  pending_q, pending_d;
  logic [IRQ_NUM-1:0]  enable_q, enable_d;
  logic [IRQ_NUM-1:0]  pend_clr;
  logic [IRQ_NUM-1:0]  req;
  logic [ID_W-1:0]     cur_id_q, cur_id_d;
  logic [ID_W-1:0]     win_id;
  logic                win_any;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [31:0]         cur_num;
  logic                claim_rd;
  logic                cmpl_wr;
  logic                en_wr;

`ifdef IRQ_SYNC_EN
  logic [IRQ_NUM-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer so asynchronous peripheral lines can be sampled safely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  assign rise     = irq_s & ~irq_q;
  assign cur_num  = 32'(cur_id_q) + 32'd1;
  assign en_wr    = reg_we && (reg_addr[3:2] == 2'd0);
  // Claim side effects only exist while a source is being presented
  assign claim_rd = reg_re && (reg_addr[3:2] == 2'd2) && (state_q == PRESENT);
  assign cmpl_wr  = reg_we && (reg_addr[3:2] == 2'd3) && (state_q == SERVICE) &&
                    (reg_wdata == cur_num);

  // Fixed priority: lowest index among pending and enabled sources wins
  always_comb begin
    req     = pending_q & enable_q;
    win_id  = '0;
    win_any = 1'b0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_id  = ID_W'(i);
        win_any = 1'b1;
      end
    end
  end

  // Next-state for the presentation FSM, pending set/clear and enable writes
  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    code_d   = code_q;
    pend_clr = '0;
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          cur_id_d = win_id;
          code_d   = CODE_W'(win_id) + CODE_W'(1);
          state_d  = PRESENT;
        end
      end
      PRESENT: begin
        // A claim beats a same-cycle enable change; a disabled source is withdrawn but stays pending
        if (claim_rd) begin
          pend_clr[cur_id_q] = 1'b1;
          code_d             = '0;
          state_d            = SERVICE;
        end else if (!enable_q[cur_id_q]) begin
          code_d  = '0;
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (cmpl_wr) begin
          state_d = IDLE;
        end
      end
      default: begin
        code_d  = '0;
        state_d = IDLE;
      end
    endcase
    // A new edge on the bit being claimed survives the clear
    pending_d = (pending_q & ~pend_clr) | rise;
    enable_d  = en_wr ? reg_wdata[IRQ_NUM-1:0] : enable_q;
  end

  // State and register flops; reset discards any in-flight claim
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      cur_id_q  <= '0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_s;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      cur_id_q  <= cur_id_d;
      code_q    <= code_d;
    end
  end

  // Register window read mux, combinational from the offset
  always_comb begin
    reg_rdata = '0;
    unique case (reg_addr[3:2])
      2'd0:    reg_rdata = 32'(enable_q);
      2'd1:    reg_rdata = 32'(pending_q);
      2'd2:    reg_rdata = (state_q == PRESENT) ? cur_num : 32'd0;
      default: reg_rdata = '0;
    endcase
  end

  assign peripheral_int_code = code_q;
  assign irq_busy            = (state_q != IDLE);

endmodule
